// File: rtl/dm_arb_pkg.sv
// Shared encodings for the data-memory access arbiter: FSM states, owner flag and the write
// constant.
package dm_arb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StDone  = 2'd3
  } arb_state_e;

  localparam logic OwnCpu  = 1'b0;
  localparam logic OwnDma  = 1'b1;
  localparam logic RwWrite = 1'b1;

endpackage

// File: rtl/dm_arb_perf_cnt.sv
// Saturating 16-bit event counter with synchronous active-low clear.
module dm_arb_perf_cnt (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        inc_i,
  output logic [15:0] count_o
);

  logic [15:0] count_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= 16'h0000;
    end else if (inc_i && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dm_access_arbiter.sv
// Arbitrates the single-ported data memory between the CPU and DMA ports, with a starvation
// guard for DMA. Define DM_ARB_PERF_EN to add the saturating grant/conflict counters.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_rw_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_ack_o,
  output logic [DW-1:0] cpu_rdata_o,
  output logic          cpu_stall_o,
  input  logic          dma_req_i,
  input  logic          dma_rw_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [DW-1:0] dma_wdata_i,
  output logic          dma_ack_o,
  output logic [DW-1:0] dma_rdata_o,
  output logic          mem_en_o,
  output logic          mem_rw_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
`ifdef DM_ARB_PERF_EN
  ,
  output logic [15:0]   perf_cpu_grants_o,
  output logic [15:0]   perf_dma_grants_o,
  output logic [15:0]   perf_conflicts_o
`endif
);

  localparam int unsigned LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e    state_q;
  logic [LW-1:0] lat_cnt_q;
  logic [SW-1:0] starve_q, starve_d;
  logic          owner_q;
  logic          mem_en_q, mem_rw_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          cpu_ack_q, dma_ack_q;
  logic [DW-1:0] cpu_rdata_q, dma_rdata_q;
  logic          dma_win;

  // DMA wins when alone, or when the CPU has starved it for STARVE_LIMIT grants.
  assign dma_win = dma_req_i & (~cpu_req_i | (starve_q == SW'(STARVE_LIMIT)));

  always_comb begin
    starve_d = starve_q;
    if (dma_win || !dma_req_i) begin
      starve_d = '0;
    end else if (starve_q != SW'(STARVE_LIMIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      owner_q     <= OwnCpu;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      mem_en_q  <= 1'b0;
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req_i || dma_req_i) begin
            owner_q     <= dma_win ? OwnDma : OwnCpu;
            mem_rw_q    <= dma_win ? dma_rw_i : cpu_rw_i;
            mem_addr_q  <= dma_win ? dma_addr_i : cpu_addr_i;
            mem_wdata_q <= dma_win ? dma_wdata_i : cpu_wdata_i;
            starve_q    <= starve_d;
            mem_en_q    <= 1'b1;
            state_q     <= StIssue;
          end
        end
        StIssue: begin
          lat_cnt_q <= LW'(MEM_LAT - 1);
          state_q   <= StWait;
        end
        StWait: begin
          if (lat_cnt_q != '0) begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end else begin
            if (mem_rw_q != RwWrite) begin
              if (owner_q == OwnDma) dma_rdata_q <= mem_rdata_i;
              else                   cpu_rdata_q <= mem_rdata_i;
            end
            if (owner_q == OwnDma) dma_ack_q <= 1'b1;
            else                   cpu_ack_q <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign cpu_ack_o   = cpu_ack_q;
  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
  assign dma_ack_o   = dma_ack_q;
  assign dma_rdata_o = dma_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_rw_o    = mem_rw_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef DM_ARB_PERF_EN
  logic arb_valid;
  assign arb_valid = (state_q == StIdle) & (cpu_req_i | dma_req_i);

  dm_arb_perf_cnt u_cnt_cpu (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (arb_valid & ~dma_win),
    .count_o (perf_cpu_grants_o)
  );

  dm_arb_perf_cnt u_cnt_dma (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (arb_valid & dma_win),
    .count_o (perf_dma_grants_o)
  );

  dm_arb_perf_cnt u_cnt_conflict (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (arb_valid & cpu_req_i & dma_req_i),
    .count_o (perf_conflicts_o)
  );
`endif

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Randomized bench for dm_access_arbiter against a transaction-level model of grants, latency
// and memory contents.
module tb_dm_access_arbiter;

  localparam int unsigned AW           = 16;
  localparam int unsigned DW           = 16;
  localparam int unsigned MEM_LAT      = 3;
  localparam int unsigned STARVE_LIMIT = 4;
  localparam int          IdlePhase    = MEM_LAT + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cpu_req, cpu_rw, dma_req, dma_rw;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_ack, cpu_stall, dma_ack;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          mem_en, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DM_ARB_PERF_EN
  logic [15:0]   perf_cpu, perf_dma, perf_conf;
`endif

  always #5 clk = ~clk;

  dm_access_arbiter #(
    .AW           (AW),
    .DW           (DW),
    .MEM_LAT      (MEM_LAT),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cpu_req_i   (cpu_req),
    .cpu_rw_i    (cpu_rw),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_ack_o   (cpu_ack),
    .cpu_rdata_o (cpu_rdata),
    .cpu_stall_o (cpu_stall),
    .dma_req_i   (dma_req),
    .dma_rw_i    (dma_rw),
    .dma_addr_i  (dma_addr),
    .dma_wdata_i (dma_wdata),
    .dma_ack_o   (dma_ack),
    .dma_rdata_o (dma_rdata),
    .mem_en_o    (mem_en),
    .mem_rw_o    (mem_rw),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
`ifdef DM_ARB_PERF_EN
    ,
    .perf_cpu_grants_o (perf_cpu),
    .perf_dma_grants_o (perf_dma),
    .perf_conflicts_o  (perf_conf)
`endif
  );

  // Memory environment: read data is valid only in the cycle exactly MEM_LAT after issue.
  logic [DW-1:0] env_mem [64];
  logic [DW:0]   rd_pipe [MEM_LAT];
  logic          env_init = 1'b0;

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 64; i++) env_mem[i] <= 16'hA595 + 16'(i);
      env_init <= 1'b1;
    end else if (mem_en && mem_rw) begin
      env_mem[mem_addr[5:0]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_rw) ? {1'b1, env_mem[mem_addr[5:0]]} : '0;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign mem_rdata = rd_pipe[MEM_LAT-1][DW] ? rd_pipe[MEM_LAT-1][DW-1:0] : 16'hDEAD;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [DW-1:0] shadow [64];
  int            phase;
  int            starve;
  bit            own_dma, own_rw;
  logic [DW-1:0] own_rd;
  logic          exp_mem_rw;
  logic [AW-1:0] exp_mem_addr;
  logic [DW-1:0] exp_mem_wdata, exp_cpu_rdata, exp_dma_rdata;
  int            n_cpu_g, n_dma_g, n_conf;
  bit            last_cack, last_dack;
  int            mode;  // 0 random, 1 continuous contention, 2 directed

  task automatic step();
    bit exp_en, exp_cack, exp_dack, win;
    @(negedge clk);
    exp_en = 0; exp_cack = 0; exp_dack = 0;
    if (!rst_n) begin
      phase = IdlePhase; starve = 0;
      exp_mem_rw = 0; exp_mem_addr = '0; exp_mem_wdata = '0;
      exp_cpu_rdata = '0; exp_dma_rdata = '0;
      n_cpu_g = 0; n_dma_g = 0; n_conf = 0;
    end else begin
      if (phase >= IdlePhase && (cpu_req || dma_req)) begin
        exp_en = 1;
        phase  = 0;
        win    = dma_req && (!cpu_req || starve == STARVE_LIMIT);
        if (cpu_req && dma_req) n_conf++;
        if (win) begin
          n_dma_g++; starve = 0;
          own_dma = 1; own_rw = dma_rw; exp_mem_addr = dma_addr; exp_mem_wdata = dma_wdata;
        end else begin
          n_cpu_g++;
          starve = dma_req ? ((starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : starve + 1) : 0;
          own_dma = 0; own_rw = cpu_rw; exp_mem_addr = cpu_addr; exp_mem_wdata = cpu_wdata;
        end
        exp_mem_rw = own_rw;
        own_rd = shadow[exp_mem_addr[5:0]];
        if (own_rw) shadow[exp_mem_addr[5:0]] = exp_mem_wdata;
      end else if (phase < IdlePhase) begin
        phase++;
      end
      if (phase == MEM_LAT + 1) begin
        exp_cack = !own_dma;
        exp_dack = own_dma;
        if (!own_rw && own_dma)  exp_dma_rdata = own_rd;
        if (!own_rw && !own_dma) exp_cpu_rdata = own_rd;
      end
    end
    check_eq("mem_en", mem_en, exp_en);
    check_eq("mem_rw", mem_rw, exp_mem_rw);
    check_eq("mem_addr", mem_addr, exp_mem_addr);
    check_eq("mem_wdata", mem_wdata, exp_mem_wdata);
    check_eq("cpu_ack", cpu_ack, exp_cack);
    check_eq("dma_ack", dma_ack, exp_dack);
    check_eq("cpu_rdata", cpu_rdata, exp_cpu_rdata);
    check_eq("dma_rdata", dma_rdata, exp_dma_rdata);
    check_eq("cpu_stall", cpu_stall, cpu_req & ~exp_cack);
`ifdef DM_ARB_PERF_EN
    check_eq("perf_cpu", perf_cpu, n_cpu_g);
    check_eq("perf_dma", perf_dma, n_dma_g);
    check_eq("perf_conf", perf_conf, n_conf);
`endif
    last_cack = exp_cack;
    last_dack = exp_dack;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return 16'($urandom) | 16'h0020;  // keeps the directed locations 0x03/0x10 untouched
  endfunction

  task automatic drive();
    bit cpu_busy, dma_busy;
    cpu_busy = (phase < IdlePhase) && !own_dma;
    dma_busy = (phase < IdlePhase) && own_dma;
    if (last_cack) begin
      cpu_req = (mode == 1) ? 1'b1 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      cpu_rw = 1'($urandom_range(0, 1)); cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
    end else if (mode == 0) begin
      if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_rw = 1'($urandom_range(0, 1));
        cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
      end else if (cpu_req && !cpu_busy && $urandom_range(0, 7) == 0) begin
        cpu_addr = rand_addr(); cpu_wdata = 16'($urandom);
      end else if (cpu_req && cpu_busy && $urandom_range(0, 31) == 0) begin
        cpu_req = 0;
      end
    end
    if (last_dack) begin
      dma_req = (mode == 1) ? 1'b1 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      dma_rw = 1'($urandom_range(0, 1)); dma_addr = rand_addr(); dma_wdata = 16'($urandom);
    end else if (mode == 0) begin
      if (!dma_req && $urandom_range(0, 3) == 0) begin
        dma_req = 1; dma_rw = 1'($urandom_range(0, 1));
        dma_addr = rand_addr(); dma_wdata = 16'($urandom);
      end else if (dma_req && !dma_busy && $urandom_range(0, 7) == 0) begin
        dma_addr = rand_addr(); dma_wdata = 16'($urandom);
      end
    end
    if (mode == 0) rst_n = ($urandom_range(0, 299) != 0);
  endtask

  task automatic cpu_access(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    cpu_req = 1; cpu_rw = rw; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin step(); n++; end while (!last_cack && n < 20);
    if (!last_cack) check_eq("cpu_ack_timeout", cpu_ack, 1);
    cpu_req = 0;
  endtask

  task automatic dma_access(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    dma_req = 1; dma_rw = rw; dma_addr = a; dma_wdata = d;
    n = 0;
    do begin step(); n++; end while (!last_dack && n < 20);
    if (!last_dack) check_eq("dma_ack_timeout", dma_ack, 1);
    dma_req = 0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) shadow[i] = 16'hA595 + 16'(i);
    phase = IdlePhase; starve = 0; own_dma = 0; own_rw = 0; own_rd = '0;
    last_cack = 0; last_dack = 0; mode = 1;
    rst_n = 0;
    cpu_req = 1; cpu_rw = 1; cpu_addr = 16'h0040; cpu_wdata = 16'h1234;
    dma_req = 1; dma_rw = 0; dma_addr = 16'h0021; dma_wdata = 16'h0000;

    // Reset held with both requests asserted, then continuous contention.
    step(); step();
    rst_n = 1;
    for (int n = 0; n < 400 && (n_cpu_g + n_dma_g) < 10; n++) begin
      step(); drive();
    end
`ifdef DM_ARB_PERF_EN
    check_eq("perf_cpu_10", perf_cpu, 8);
    check_eq("perf_dma_10", perf_dma, 2);
    check_eq("perf_conf_10", perf_conf, 10);
`endif

    // Reset while the current access is in its latency wait: no ack must follow.
    mode = 2;
    for (int n = 0; n < 20 && phase != 2; n++) begin
      step(); drive();
    end
    rst_n = 0; cpu_req = 0; dma_req = 0;
    step();
    rst_n = 1;
    repeat (6) step();

    // Directed CPU write/read and a lone DMA read.
    cpu_access(1'b1, 16'h0003, 16'hFFFF);
    cpu_access(1'b0, 16'h0003, 16'h0000);
    check_eq("cpu_rd_0003", cpu_rdata, 16'hFFFF);
    repeat (2) step();
    dma_access(1'b0, 16'h0010, 16'h0000);
    check_eq("dma_rd_0010", dma_rdata, 16'hA5A5);
    check_eq("cpu_rdata_kept", cpu_rdata, 16'hFFFF);
    repeat (2) step();

    // Randomized traffic with occasional resets.
    mode = 0;
    for (int n = 0; n < 3000; n++) begin
      step(); drive();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
